// File: rtl/logip_pkg.sv
// Shared types and constants for the trigger block: stage configuration
// layout, trigger level/delay widths and the arm/run state encoding.
package logip_pkg;

  localparam int TRIG_LVL_W = 2;
  localparam int TRIG_DLY_W = 16;
  localparam int TRIG_CH_W  = 5;

  localparam logic [TRIG_LVL_W-1:0] TRIG_LVL_MAX = '1;

  // Per-stage configuration as loaded by set_cfg_i.
  typedef struct packed {
    logic                  start;
    logic                  serial;
    logic [TRIG_CH_W-1:0]  channel;
    logic [TRIG_LVL_W-1:0] level;
    logic [TRIG_DLY_W-1:0] delay;
  } trig_cfg_t;

  // Arm/run progression of the whole trigger block.
  typedef enum logic [1:0] {
    TRIG_IDLE  = 2'd0,
    TRIG_ARMED = 2'd1,
    TRIG_RUN   = 2'd2
  } trig_state_t;

  // Unpack a command-decoder word into the stage configuration fields:
  // [15:0] delay, [17:16] level, [24:20] channel, [26] serial, [27] start.
  function automatic trig_cfg_t trig_cfg_decode(input logic [31:0] word);
    trig_cfg_t cfg;
    cfg.delay   = word[15:0];
    cfg.level   = word[17:16];
    cfg.channel = word[24:20];
    cfg.serial  = word[26];
    cfg.start   = word[27];
    return cfg;
  endfunction

endpackage

// File: rtl/trigger_unit_if.sv
// Bundle of the trigger block's configuration, arm and sample-stream
// signals. master = the driver side (decoder/sampler), slave = trigger_unit.
interface trigger_unit_if #(
  parameter int CHLS   = 32,
  parameter int STAGES = 4
);
  localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [31:0]        cfg_data_i;
  logic [STAGE_W-1:0] cfg_stage_i;
  logic               set_mask_i;
  logic               set_val_i;
  logic               set_cfg_i;
  logic               arm_i;
  logic [CHLS-1:0]    smpls_i;
  logic               stb_i;
  logic [CHLS-1:0]    smpls_o;
  logic               stb_o;
  logic               run_o;
  logic               armed_o;

  modport master (
    output cfg_data_i, cfg_stage_i, set_mask_i, set_val_i, set_cfg_i,
    output arm_i, smpls_i, stb_i,
    input  smpls_o, stb_o, run_o, armed_o
  );

  modport slave (
    input  cfg_data_i, cfg_stage_i, set_mask_i, set_val_i, set_cfg_i,
    input  arm_i, smpls_i, stb_i,
    output smpls_o, stb_o, run_o, armed_o
  );

endinterface

// File: rtl/trigger_stage.sv
// One trigger stage: mask/value/config registers, match logic, delay
// counter and fired flag. Optional macro TRIG_SERIAL_EN adds a per-stage
// shift register fed from one selected channel, matched instead of the
// parallel sample when the stage's serial bit is set.
module trigger_stage
  import logip_pkg::*;
#(
  parameter int CHLS = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic [31:0]           i_cfg_data,
  input  logic                  i_set_mask,
  input  logic                  i_set_val,
  input  logic                  i_set_cfg,
  input  logic                  i_arm,
  input  logic                  i_eval,
  input  logic [TRIG_LVL_W-1:0] i_level,
  input  logic [CHLS-1:0]       i_smpls,
  output logic                  o_fire,
  output logic                  o_start
);

  logic [CHLS-1:0]       r_mask;
  logic [CHLS-1:0]       r_value;
  trig_cfg_t             r_cfg;
  logic                  r_fired;
  logic                  r_counting;
  logic [TRIG_DLY_W-1:0] r_cnt;

  logic [CHLS-1:0] w_data;
  logic            w_match;
  logic            w_eligible;
  logic            w_cnt_done;
  logic            w_fire;
  logic            w_start_cnt;
  logic            w_unused;

  // Bits of the config word this stage never looks at (and, without the
  // serial option, the stored serial/channel fields).
  assign w_unused = ^{i_cfg_data, r_cfg.serial, r_cfg.channel};

  // Configuration registers; each set flag loads independently.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_mask  <= '0;
      r_value <= '0;
      r_cfg   <= '0;
    end else begin
      if (i_set_mask) r_mask  <= i_cfg_data[CHLS-1:0];
      if (i_set_val)  r_value <= i_cfg_data[CHLS-1:0];
      if (i_set_cfg)  r_cfg   <= trig_cfg_decode(i_cfg_data);
    end
  end

`ifdef TRIG_SERIAL_EN
  localparam int CH_IDX_W = (CHLS > 1) ? $clog2(CHLS) : 1;

  logic [CHLS-1:0]     r_shreg;
  logic [CHLS-1:0]     w_shreg_next;
  logic [CH_IDX_W-1:0] w_chan;
  logic                w_ser_bit;

  assign w_chan    = r_cfg.channel[CH_IDX_W-1:0];
  assign w_ser_bit = (int'(w_chan) < CHLS) ? i_smpls[w_chan] : 1'b0;

  if (CHLS > 1) begin : g_sh_wide
    assign w_shreg_next = {r_shreg[CHLS-2:0], w_ser_bit};
  end else begin : g_sh_one
    assign w_shreg_next = w_ser_bit;
  end

  // Matching uses the register as it will be after this strobe's shift.
  assign w_data = r_cfg.serial ? w_shreg_next : i_smpls;

  // Serial history: cleared on arm, shifts on every evaluated strobe.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_shreg <= '0;
    end else if (i_arm) begin
      r_shreg <= '0;
    end else if (i_eval) begin
      r_shreg <= w_shreg_next;
    end
  end
`else
  assign w_data = i_smpls;
`endif

  assign w_match     = ((w_data ^ r_value) & r_mask) == '0;
  assign w_eligible  = i_eval && !r_fired && !r_counting && (r_cfg.level == i_level);
  // A counting stage fires on the strobe that brings its count to zero.
  assign w_cnt_done  = i_eval && r_counting && (r_cnt == TRIG_DLY_W'(1));
  assign w_start_cnt = w_eligible && w_match && (r_cfg.delay != '0);
  assign w_fire      = (w_eligible && w_match && (r_cfg.delay == '0)) || w_cnt_done;

  assign o_fire  = w_fire;
  assign o_start = r_cfg.start;

  // Fired/counting flags and delay counter, only touched on strobes or arm.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_fired    <= 1'b0;
      r_counting <= 1'b0;
      r_cnt      <= '0;
    end else if (i_arm) begin
      r_fired    <= 1'b0;
      r_counting <= 1'b0;
      r_cnt      <= '0;
    end else if (w_fire) begin
      r_fired    <= 1'b1;
      r_counting <= 1'b0;
      r_cnt      <= '0;
    end else if (w_start_cnt) begin
      r_counting <= 1'b1;
      r_cnt      <= r_cfg.delay;
    end else if (i_eval && r_counting) begin
      r_cnt      <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/trigger_unit.sv
// Multi-stage trigger: evaluates strobed samples against STAGES trigger
// stages, tracks the trigger level and raises a sticky run flag when a
// start stage fires. Samples/strobe are forwarded one cycle late so they
// line up with run_o. Optional macro TRIG_SERIAL_EN enables serial-mode
// matching inside each stage.
module trigger_unit
  import logip_pkg::*;
#(
  parameter int CHLS   = 32,
  parameter int STAGES = 4
) (
  input  logic          clk_i,
  input  logic          rst_in,
  trigger_unit_if.slave bus
);

  localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  trig_state_t           r_state;
  trig_state_t           w_state_next;
  logic [TRIG_LVL_W-1:0] r_level;
  logic [CHLS-1:0]       r_smpls_o;
  logic                  r_stb_o;

  logic              w_eval;
  logic [STAGES-1:0] w_fire;
  logic [STAGES-1:0] w_start;
  logic              w_fire_start;
  logic              w_fire_inc;

  // Arm takes priority: a strobe in the arm cycle is forwarded but not evaluated.
  assign w_eval = (r_state == TRIG_ARMED) && bus.stb_i && !bus.arm_i;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic w_sel;
      assign w_sel = (bus.cfg_stage_i == STAGE_W'(gi));

      trigger_stage #(
        .CHLS(CHLS)
      ) u_stage (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .i_cfg_data (bus.cfg_data_i),
        .i_set_mask (bus.set_mask_i && w_sel),
        .i_set_val  (bus.set_val_i && w_sel),
        .i_set_cfg  (bus.set_cfg_i && w_sel),
        .i_arm      (bus.arm_i),
        .i_eval     (w_eval),
        .i_level    (r_level),
        .i_smpls    (bus.smpls_i),
        .o_fire     (w_fire[gi]),
        .o_start    (w_start[gi])
      );
    end
  endgenerate

  assign w_fire_start = |(w_fire & w_start);
  assign w_fire_inc   = |(w_fire & ~w_start);

  // Arm/run state register.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= TRIG_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next arm/run state: arm from anywhere, run once a start stage fires.
  always_comb begin
    w_state_next = r_state;
    if (bus.arm_i) begin
      w_state_next = TRIG_ARMED;
    end else if ((r_state == TRIG_ARMED) && w_fire_start) begin
      w_state_next = TRIG_RUN;
    end
  end

  // Trigger level: one step per cycle however many non-start stages fire.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_level <= '0;
    end else if (bus.arm_i) begin
      r_level <= '0;
    end else if (w_fire_inc && (r_level != TRIG_LVL_MAX)) begin
      r_level <= r_level + 1'b1;
    end
  end

  // One-cycle sample/strobe delay to stay aligned with run_o.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_smpls_o <= '0;
      r_stb_o   <= 1'b0;
    end else begin
      r_smpls_o <= bus.smpls_i;
      r_stb_o   <= bus.stb_i;
    end
  end

  assign bus.smpls_o = r_smpls_o;
  assign bus.stb_o   = r_stb_o;
  assign bus.run_o   = (r_state == TRIG_RUN);
  assign bus.armed_o = (r_state == TRIG_ARMED);

endmodule

// File: tb/tb_trigger_unit.sv
// Self-checking bench for trigger_unit: directed scenarios plus random
// stimulus, checked through a scoreboard against a behavioural model.
module tb_trigger_unit;

  localparam int CHLS   = 8;
  localparam int STAGES = 4;

  logic clk_i  = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_i = ~clk_i;

  trigger_unit_if #(.CHLS(CHLS), .STAGES(STAGES)) bus ();

  trigger_unit #(.CHLS(CHLS), .STAGES(STAGES)) dut (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct {
    logic [CHLS-1:0] smpls;
    logic            run;
    logic            armed;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  logic [CHLS-1:0] m_mask[STAGES];
  logic [CHLS-1:0] m_val[STAGES];
  logic [CHLS-1:0] m_sh[STAGES];
  int              m_delay[STAGES];
  int              m_lvl[STAGES];
  int              m_chan[STAGES];
  int              m_cnt[STAGES];
  bit              m_serial[STAGES];
  bit              m_start[STAGES];
  bit              m_fired[STAGES];
  bit              m_counting[STAGES];
  int              m_level;
  bit              m_run;
  bit              m_armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_cfg(input int dly, input int lvl, input int chan,
                                         input bit serial, input bit start);
    logic [31:0] w;
    w = '0;
    w[15:0]  = dly[15:0];
    w[17:16] = lvl[1:0];
    w[24:20] = chan[4:0];
    w[26]    = serial;
    w[27]    = start;
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) begin
      m_mask[k] = '0; m_val[k] = '0; m_sh[k] = '0;
      m_delay[k] = 0; m_lvl[k] = 0; m_chan[k] = 0; m_cnt[k] = 0;
      m_serial[k] = 0; m_start[k] = 0; m_fired[k] = 0; m_counting[k] = 0;
    end
    m_level = 0; m_run = 0; m_armed = 0;
  endtask

  task automatic model_arm();
    for (int k = 0; k < STAGES; k++) begin
      m_fired[k] = 0; m_counting[k] = 0; m_cnt[k] = 0; m_sh[k] = '0;
    end
    m_level = 0; m_run = 0; m_armed = 1;
  endtask

  task automatic model_strobe(input logic [CHLS-1:0] s);
    bit any_start;
    bit any_inc;
    any_start = 0;
    any_inc   = 0;
    if (!m_armed) return;
    for (int k = 0; k < STAGES; k++) begin
      logic [CHLS-1:0] d;
      bit fire;
      d    = s;
      fire = 0;
`ifdef TRIG_SERIAL_EN
      m_sh[k] = (m_sh[k] << 1) | CHLS'(s[m_chan[k] % CHLS]);
      if (m_serial[k]) d = m_sh[k];
`endif
      if (m_counting[k]) begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) fire = 1;
      end else if (!m_fired[k] && (m_lvl[k] == m_level) &&
                   (((d ^ m_val[k]) & m_mask[k]) == '0)) begin
        if (m_delay[k] == 0) fire = 1;
        else begin
          m_counting[k] = 1;
          m_cnt[k]      = m_delay[k];
        end
      end
      if (fire) begin
        m_fired[k]    = 1;
        m_counting[k] = 0;
        if (m_start[k]) any_start = 1;
        else            any_inc   = 1;
      end
    end
    if (any_start) begin
      m_run   = 1;
      m_armed = 0;
    end
    if (any_inc && m_level < 3) m_level++;
  endtask

  // One clock of stimulus; a strobe queues its expected forwarded response.
  task automatic step(input bit arm, input bit stb, input logic [CHLS-1:0] s);
    exp_t e;
    bus.arm_i   = arm;
    bus.stb_i   = stb;
    bus.smpls_i = s;
    if (arm)      model_arm();
    else if (stb) model_strobe(s);
    if (stb) begin
      e.smpls = s; e.run = m_run; e.armed = m_armed;
      sb_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    bus.arm_i = 1'b0;
    bus.stb_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  task automatic cfg_stage(input int st, input logic [CHLS-1:0] mask,
                           input logic [CHLS-1:0] val, input logic [31:0] w);
    bus.cfg_stage_i = st[1:0];
    bus.cfg_data_i  = 32'(mask);
    bus.set_mask_i  = 1'b1;
    m_mask[st]      = mask;
    @(posedge clk_i); #1;
    bus.set_mask_i  = 1'b0;
    bus.cfg_data_i  = 32'(val);
    bus.set_val_i   = 1'b1;
    m_val[st]       = val;
    @(posedge clk_i); #1;
    bus.set_val_i   = 1'b0;
    bus.cfg_data_i  = w;
    bus.set_cfg_i   = 1'b1;
    m_delay[st]  = int'(w[15:0]);
    m_lvl[st]    = int'(w[17:16]);
    m_chan[st]   = int'(w[24:20]);
    m_serial[st] = w[26];
    m_start[st]  = w[27];
    @(posedge clk_i); #1;
    bus.set_cfg_i   = 1'b0;
  endtask

  // Mask and value loaded in parallel from one word.
  task automatic cfg_maskval(input int st, input logic [CHLS-1:0] data);
    bus.cfg_stage_i = st[1:0];
    bus.cfg_data_i  = 32'(data);
    bus.set_mask_i  = 1'b1;
    bus.set_val_i   = 1'b1;
    m_mask[st] = data;
    m_val[st]  = data;
    @(posedge clk_i); #1;
    bus.set_mask_i = 1'b0;
    bus.set_val_i  = 1'b0;
  endtask

  task automatic disable_stage(input int st);
    cfg_stage(st, 8'hFF, 8'hFF, mk_cfg(0, 3, 0, 0, 0));
  endtask

  // Monitor: every forwarded strobe is compared with the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_in && bus.stb_o) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stb_o_unexpected: got 1 expected 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("smpls_o", 32'(bus.smpls_o), 32'(e.smpls));
        check("run_o",   32'(bus.run_o),   32'(e.run));
        check("armed_o", 32'(bus.armed_o), 32'(e.armed));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_data_i = '0; bus.cfg_stage_i = '0;
    bus.set_mask_i = 0; bus.set_val_i = 0; bus.set_cfg_i = 0;
    bus.arm_i = 0; bus.stb_i = 0; bus.smpls_i = '0;
    model_reset();
    #12;
    check("rst_run",   32'(bus.run_o),   0);
    check("rst_armed", 32'(bus.armed_o), 0);
    check("rst_stb",   32'(bus.stb_o),   0);
    check("rst_smpls", 32'(bus.smpls_o), 0);
    @(negedge clk_i);
    rst_in = 1'b1;
    @(posedge clk_i); #1;

    // Single start stage, immediate fire
    cfg_stage(0, 8'hFF, 8'h5A, mk_cfg(0, 0, 0, 0, 1));
    for (int s = 1; s < STAGES; s++) disable_stage(s);
    step(1, 0, '0);
    check("t1_armed", 32'(bus.armed_o), 1);
    step(0, 1, 8'h00);
    step(0, 1, 8'h5A);
    check("t1_run", 32'(bus.run_o), 1);
    check("t1_armed_fall", 32'(bus.armed_o), 0);
    idle(2);

    // Two levels, start on level 1; re-arm clears run
    cfg_stage(0, 8'hFF, 8'h01, mk_cfg(0, 0, 0, 0, 0));
    cfg_stage(1, 8'hFF, 8'h02, mk_cfg(0, 1, 0, 0, 1));
    step(1, 0, '0);
    check("t2_rearm_run", 32'(bus.run_o), 0);
    step(0, 1, 8'h02);
    step(0, 1, 8'h01);
    check("t2_run_early", 32'(bus.run_o), 0);
    step(0, 1, 8'h02);
    check("t2_run", 32'(bus.run_o), 1);
    idle(2);

    // Delay 3 with idle cycles between strobes
    cfg_stage(0, 8'hFF, 8'hAA, mk_cfg(3, 0, 0, 0, 1));
    disable_stage(1);
    step(1, 0, '0);
    step(0, 1, 8'hAA);
    idle(1);
    step(0, 1, 8'h00);
    idle(2);
    step(0, 1, 8'h00);
    check("t3_run_early", 32'(bus.run_o), 0);
    step(0, 1, 8'h00);
    check("t3_run", 32'(bus.run_o), 1);
    idle(2);

    // Arm coincident with a matching strobe does not fire
    cfg_stage(0, 8'hFF, 8'hAA, mk_cfg(0, 0, 0, 0, 1));
    step(1, 1, 8'hAA);
    check("t4_arm_stb_run", 32'(bus.run_o), 0);
    step(0, 1, 8'h00);
    check("t4_nomatch_run", 32'(bus.run_o), 0);
    step(0, 1, 8'hAA);
    check("t4_run", 32'(bus.run_o), 1);
    idle(2);

    // Reset in the middle of a delay count
    cfg_stage(0, 8'hFF, 8'h33, mk_cfg(5, 0, 0, 0, 1));
    step(1, 0, '0);
    step(0, 1, 8'h33);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    idle(1);
    #2 rst_in = 1'b0;
    model_reset();
    #1;
    check("t5_rst_run",   32'(bus.run_o),   0);
    check("t5_rst_armed", 32'(bus.armed_o), 0);
    check("t5_rst_stb",   32'(bus.stb_o),   0);
    check("t5_rst_smpls", 32'(bus.smpls_o), 0);
    @(posedge clk_i); #3;
    rst_in = 1'b1;
    @(posedge clk_i); #1;
    step(0, 1, 8'h33);
    check("t5_disarmed", 32'(bus.armed_o), 0);
    cfg_stage(0, 8'hFF, 8'h33, mk_cfg(5, 0, 0, 0, 1));
    for (int s = 1; s < STAGES; s++) disable_stage(s);
    step(1, 0, '0);
    step(0, 1, 8'h33);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    check("t5_run_early", 32'(bus.run_o), 0);
    step(0, 1, 8'h00);
    check("t5_run", 32'(bus.run_o), 1);
    idle(2);

`ifdef TRIG_SERIAL_EN
    // Serial match on channel 2: history 1,0,1,1 -> 0x0B
    cfg_stage(0, 8'h0F, 8'h0B, mk_cfg(0, 0, 2, 1, 1));
    step(1, 0, '0);
    step(0, 1, 8'h04);
    step(0, 1, 8'h00);
    step(0, 1, 8'h04);
    check("ser_run_early", 32'(bus.run_o), 0);
    step(0, 1, 8'h04);
    check("ser_run", 32'(bus.run_o), 1);
    idle(2);
`endif

    // Random configurations and strobes against the model
    for (int s = 0; s < STAGES; s++) begin
      if ($urandom_range(0, 1) == 0) cfg_maskval(s, 8'($urandom));
      cfg_stage(s, 8'($urandom & $urandom), 8'($urandom),
                mk_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
                       1'($urandom), ($urandom_range(0, 2) == 0)));
    end
    step(1, 0, '0);
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [CHLS-1:0] smp;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1) == 0) smp = m_val[$urandom_range(0, STAGES - 1)];
      else                           smp = 8'($urandom);
      if (r < 4 || (m_run && r < 20)) begin
        step(1, 1'($urandom), smp);
      end else if (r < 7) begin
        int st;
        st = $urandom_range(0, STAGES - 1);
        cfg_stage(st, 8'($urandom & $urandom), 8'($urandom),
                  mk_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
                         1'($urandom), ($urandom_range(0, 2) == 0)));
      end else if (r < 65) begin
        step(0, 1, smp);
      end else begin
        step(0, 0, '0);
      end
    end

    idle(3);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_unit.md
# trigger_unit

Multi-stage trigger block sitting directly downstream of the sampler. It consumes the sampler's sample word and strobe and compares each strobed sample against per-stage mask/value pairs, advancing a trigger level. When a stage flagged "start" fires, it raises `run_o` so the capture stage begins storing. Samples and strobe are forwarded one cycle delayed so they stay aligned with `run_o`.

## Interface
- `CHLS`, 32, number of input channels (1..32)
- `STAGES`, 4, number of trigger stages (power of two, 1..4)

Ports:
- `clk_i`  in  1  system clock
- `rst_in`  in  1  reset; asynchronous, active-low
- `cfg_data_i`  in  32  configuration word from command decoder
- `cfg_stage_i`  in  $clog2(STAGES) (min 1)  stage addressed by set_* flags
- `set_mask_i`  in  1  load `cfg_data_i[CHLS-1:0]` as mask of addressed stage
- `set_val_i`  in  1  load `cfg_data_i[CHLS-1:0]` as value of addressed stage
- `set_cfg_i`  in  1  load stage config: [15:0] delay, [17:16] level, [24:20] channel, [26] serial, [27] start
- `arm_i`  in  1  single-cycle pulse; clears trigger state and arms
- `smpls_i`  in  CHLS  sample word from sampler
- `stb_i`  in  1  sample valid, single cycle
- `smpls_o`  out  CHLS  `smpls_i` registered
- `stb_o`  out  1  `stb_i` registered
- `run_o`  out  1  capture-start flag, sticky
- `armed_o`  out  1  armed and not yet run

## Operation
- Reset: every register clears; mask, value, cfg, `run_o`, `armed_o`, `stb_o`, `smpls_o`, level, and all counters read 0.
- Config writes are accepted at any time and take effect the following cycle. Simultaneous set_* flags load their respective registers in parallel.
- `arm_i`: level←0, all stage fired/counting flags←0, delay counters←0, `run_o`←0, `armed_o`←1. If `arm_i` and `stb_i` coincide, arm wins and that sample is not evaluated.
- A stage is eligible when all of these hold: `armed_o`=1, stage level == current level, the stage has not fired since arm, and the stage is not counting.
- Match (parallel mode): ((smpls_i ^ value) & mask) == 0 on a strobe. Mask 0 matches every strobe.
- Match on a strobe: if delay==0 the stage fires immediately. Otherwise it enters counting with cnt=delay. Each subsequent strobe decrements cnt, and the stage fires on the strobe where cnt reaches 0.
- Fire: stage fired←1. If start=1, `run_o`←1 and `armed_o`←0. Else level←level+1, saturating at 3. Multiple stages firing in the same cycle increment level by 1 only.
- Once `run_o`=1, evaluation stops until the next `arm_i`.
- Strobe-free cycles change no trigger state.

## Timing
- Strobe at edge t: `smpls_o`/`stb_o` valid at t+1.
- A firing caused by that strobe shows in `run_o`/level at t+1, so `run_o` rises in the same cycle as `stb_o` for the triggering sample.
- Delay D means `run_o` rises together with `stb_o` of the D-th strobe after the matching one.
- Reset asserted mid-count: all state is cleared asynchronously. After reset the block stays disarmed until `arm_i`.

## Configuration
- `TRIG_SERIAL_EN` defined: each stage has a CHLS-bit shift register. On every strobe it shifts left and takes in `smpls_i[channel]`, using `channel[$clog2(CHLS)-1:0]`. When serial=1, the match compares the post-shift register instead of `smpls_i`. Shift registers run whenever armed and clear on `arm_i`.
- `TRIG_SERIAL_EN` undefined: the serial bit is stored but ignored, no shift logic is built, and all stages use parallel mode.

## Structure
- `logip_pkg`: `trig_cfg_t` packed struct (delay, level, channel, serial, start), plus `TRIG_LVL_W=2`, `TRIG_DLY_W=16`.
- Sub-module `trigger_stage`: holds one stage's mask/value/cfg registers, match logic, delay counter, fired flag, and optional shift register. It is instantiated STAGES times, and the top owns level, `run_o`, `armed_o`, and the output registers.

## Test plan
- Stage0 mask=0xFF, value=0x5A, start=1, delay=0; arm; strobe 0x00 then 0x5A → `run_o` rises with `stb_o` of 0x5A, `armed_o` falls.
- Stage0 level0 match 0x01 (no start), stage1 level1 match 0x02 start → strobes 0x02, 0x01, 0x02 → `run_o` only on the third sample's `stb_o`.
- Stage0 start, delay=3, match 0xAA → strobes AA,00,00,00 → `run_o` with the fourth sample. Idle cycles between strobes do not count.
- `arm_i` coincident with a matching strobe → no fire. A re-arm after `run_o`=1 clears `run_o` next cycle.
- Reset pulse during a delay count of 5 → all outputs 0 immediately. After arm, the sequence restarts from level 0.
- With `TRIG_SERIAL_EN`: CHLS=8, channel=2, mask=0x0F, value=0x0B, serial, start; drive bit2 sequence 1,0,1,1 → `run_o` after the fourth strobe.
